am2940_sequencer: RTL and testbench
===================================

AM2940_SEQUENCER -- requirements
Module: am2940_sequencer

Interface
REQ-001 Parameter: DW, default 8, width of the Am2940 data bus and all address/count fields.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle request to program and run a transfer; sampled only in IDLE.
REQ-005 abort  input  1  terminate any in-progress sequence.
REQ-006 cr_cfg  input  3  control-register value (CR[2]=direction, CR[1:0]=done mode).
REQ-007 addr_cfg  input  DW  starting address.
REQ-008 wc_cfg  input  DW  word count; 0 means 2^DW.
REQ-009 xfer_req  output  1  request one word transfer from the memory side.
REQ-010 xfer_ack  input  1  memory side completed the requested word.
REQ-011 done_in  input  1  DONE from the Am2940.
REQ-012 i_out  output  3  Am2940 instruction code I[2:0].
REQ-013 d_out  output  DW  data driven onto the Am2940 D bus.
REQ-014 d_oe  output  1  d_out valid/drive enable.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 xfer_cnt  output  DW  words stepped since the last start.
REQ-017 done_irq  output  1  one-cycle pulse on normal completion.
REQ-018 abort_irq  output  1  one-cycle pulse on abort.

Function
REQ-019 The FSM SHALL have the states IDLE, WR_CR, LD_ADDR, LD_WC, RUN, STEP, CHK.
REQ-020 In IDLE, i_out SHALL be 001 (read CR, non-destructive) and d_oe SHALL be 0.
REQ-021 start in IDLE SHALL clear xfer_cnt and move to WR_CR on the next edge; start outside IDLE SHALL be ignored.
REQ-022 WR_CR SHALL drive i_out=000, d_out={0..,cr_cfg}, d_oe=1 for exactly one cycle, then go to LD_ADDR.
REQ-023 LD_ADDR SHALL drive i_out=101, d_out=addr_cfg, d_oe=1 for one cycle, then go to LD_WC.
REQ-024 When cr_cfg[1:0]==01 (address-compare mode), LD_ADDR SHALL go directly to RUN and LD_WC SHALL be skipped.
REQ-025 LD_WC SHALL drive i_out=110, d_out=wc_cfg, d_oe=1 for one cycle, then go to RUN.
REQ-026 cr_cfg, addr_cfg and wc_cfg SHALL be captured at start; later changes SHALL have no effect on the running sequence.
REQ-027 RUN SHALL hold xfer_req=1 and i_out=001 until xfer_ack=1, then go to STEP.
REQ-028 STEP SHALL drive i_out=111 for exactly one cycle with xfer_req=0, increment xfer_cnt (modulo 2^DW), and go to CHK.
REQ-029 CHK SHALL sample done_in; if done_in=1, go to IDLE and pulse done_irq; otherwise return to RUN.
REQ-030 First xfer_req SHALL assert 4 cycles after the start edge (3 when LD_WC is skipped).
REQ-031 abort SHALL have priority over start, xfer_ack and done_in in every non-IDLE state: next state IDLE, abort_irq pulsed, no STEP issued, xfer_cnt held.
REQ-032 abort in IDLE SHALL be ignored and SHALL NOT pulse abort_irq.
REQ-033 done_irq and abort_irq SHALL never be high in the same cycle.
REQ-034 done_in SHALL be ignored outside CHK.
REQ-035 All outputs SHALL be registered.

Reset
REQ-036 rst_n low SHALL immediately force IDLE, i_out=001, d_out=0, d_oe=0, xfer_req=0, busy=0, xfer_cnt=0, done_irq=0, abort_irq=0.
REQ-037 Reset mid-sequence SHALL discard the captured configuration with no interrupt pulse.

Structure
REQ-038 Package am2940_pkg SHALL hold the eight Am2940 instruction-code constants and the sequencer state enum.
REQ-039 The block SHALL be a single module with no sub-modules.

Verification
REQ-040 Reset, then start with cr=000, addr=8'h10, wc=8'h03; ack every request; done_in high on the 3rd CHK -> i_out sequence 000,101,110, then three 111 steps, xfer_cnt=3, one done_irq.
REQ-041 cr=001, addr=8'h20 -> no 110 issued; first xfer_req 3 cycles after start.
REQ-042 abort in the same cycle as the 2nd xfer_ack -> no second 111, xfer_cnt=1, abort_irq pulse, busy=0 the next cycle.
REQ-043 start pulsed while busy, and cfg inputs changed mid-run -> ignored; the D bus carries the originally captured values.
REQ-044 wc=8'h00 with 256 acks and done_in only on the last CHK -> xfer_cnt wraps to 0, done_irq once.
REQ-045 rst_n asserted during RUN -> all outputs at reset values asynchronously, no irq pulse.

Source files
------------

// File: rtl/am2940_pkg.sv
// Shared definitions for the Am2940 DMA address-generator sequencer:
// the eight Am2940 instruction codes and the sequencer state encoding.
package am2940_pkg;

  localparam logic [2:0] I_WR_CR   = 3'b000;
  localparam logic [2:0] I_RD_CR   = 3'b001;
  localparam logic [2:0] I_RD_WC   = 3'b010;
  localparam logic [2:0] I_RD_ADDR = 3'b011;
  localparam logic [2:0] I_REINIT  = 3'b100;
  localparam logic [2:0] I_LD_ADDR = 3'b101;
  localparam logic [2:0] I_LD_WC   = 3'b110;
  localparam logic [2:0] I_ENCT    = 3'b111;

  // Done mode in which the chip compares against the address register only.
  localparam logic [1:0] MODE_ADDR_CMP = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_CR   = 3'd1,
    S_LD_ADDR = 3'd2,
    S_LD_WC   = 3'd3,
    S_RUN     = 3'd4,
    S_STEP    = 3'd5,
    S_CHK     = 3'd6
  } state_t;

endpackage

// File: rtl/am2940_sequencer.sv
// Programs an Am2940 (CR, address, word count) and then steps it once per
// acknowledged memory transfer until DONE is seen or the sequence is aborted.
module am2940_sequencer
  import am2940_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [2:0]    cr_cfg,
  input  logic [DW-1:0] addr_cfg,
  input  logic [DW-1:0] wc_cfg,
  output logic          xfer_req,
  input  logic          xfer_ack,
  input  logic          done_in,
  output logic [2:0]    i_out,
  output logic [DW-1:0] d_out,
  output logic          d_oe,
  output logic          busy,
  output logic [DW-1:0] xfer_cnt,
  output logic          done_irq,
  output logic          abort_irq
);

  localparam logic [DW-1:0] CNT_ONE = {{(DW-1){1'b0}}, 1'b1};

  state_t        state_r, state_nx_s;
  logic [2:0]    cr_r;
  logic [DW-1:0] addr_r, wc_r;
  logic [2:0]    cr_src_s;
  logic          load_s;
  logic [DW-1:0] cnt_nx_s;
  logic          done_nx_s, abort_nx_s;
  logic [2:0]    i_nx_s;
  logic [DW-1:0] d_nx_s;
  logic          oe_nx_s, req_nx_s;

  // WR_CR is only ever entered on the capture edge, so its data comes straight from the input.
  assign cr_src_s = load_s ? cr_cfg : cr_r;

  // Next-state, counter and interrupt decode; abort outranks everything outside IDLE.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = xfer_cnt;
    done_nx_s  = 1'b0;
    abort_nx_s = 1'b0;
    load_s     = 1'b0;
    if ((state_r != S_IDLE) && abort) begin
      state_nx_s = S_IDLE;
      abort_nx_s = 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_nx_s = S_WR_CR;
            cnt_nx_s   = {DW{1'b0}};
            load_s     = 1'b1;
          end else begin
            state_nx_s = S_IDLE;
          end
        end
        S_WR_CR:   state_nx_s = S_LD_ADDR;
        S_LD_ADDR: begin
          if (cr_r[1:0] == MODE_ADDR_CMP) begin
            state_nx_s = S_RUN;
          end else begin
            state_nx_s = S_LD_WC;
          end
        end
        S_LD_WC:   state_nx_s = S_RUN;
        S_RUN: begin
          if (xfer_ack) begin
            state_nx_s = S_STEP;
            cnt_nx_s   = xfer_cnt + CNT_ONE;
          end else begin
            state_nx_s = S_RUN;
          end
        end
        S_STEP:    state_nx_s = S_CHK;
        S_CHK: begin
          if (done_in) begin
            state_nx_s = S_IDLE;
            done_nx_s  = 1'b1;
          end else begin
            state_nx_s = S_RUN;
          end
        end
        default:   state_nx_s = S_IDLE;
      endcase
    end
  end

  // Output decode from the next state so every output leaves a flop aligned with its state.
  always_comb begin
    i_nx_s   = I_RD_CR;
    d_nx_s   = {DW{1'b0}};
    oe_nx_s  = 1'b0;
    req_nx_s = 1'b0;
    case (state_nx_s)
      S_WR_CR: begin
        i_nx_s  = I_WR_CR;
        d_nx_s  = {{(DW-3){1'b0}}, cr_src_s};
        oe_nx_s = 1'b1;
      end
      S_LD_ADDR: begin
        i_nx_s  = I_LD_ADDR;
        d_nx_s  = addr_r;
        oe_nx_s = 1'b1;
      end
      S_LD_WC: begin
        i_nx_s  = I_LD_WC;
        d_nx_s  = wc_r;
        oe_nx_s = 1'b1;
      end
      S_RUN:   req_nx_s = 1'b1;
      S_STEP:  i_nx_s   = I_ENCT;
      default: i_nx_s   = I_RD_CR;
    endcase
  end

  // State, captured configuration and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      cr_r      <= 3'b000;
      addr_r    <= {DW{1'b0}};
      wc_r      <= {DW{1'b0}};
      i_out     <= I_RD_CR;
      d_out     <= {DW{1'b0}};
      d_oe      <= 1'b0;
      xfer_req  <= 1'b0;
      busy      <= 1'b0;
      xfer_cnt  <= {DW{1'b0}};
      done_irq  <= 1'b0;
      abort_irq <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      if (load_s) begin
        cr_r   <= cr_cfg;
        addr_r <= addr_cfg;
        wc_r   <= wc_cfg;
      end else begin
        cr_r   <= cr_r;
        addr_r <= addr_r;
        wc_r   <= wc_r;
      end
      i_out     <= i_nx_s;
      d_out     <= d_nx_s;
      d_oe      <= oe_nx_s;
      xfer_req  <= req_nx_s;
      busy      <= (state_nx_s != S_IDLE);
      xfer_cnt  <= cnt_nx_s;
      done_irq  <= done_nx_s;
      abort_irq <= abort_nx_s;
    end
  end

endmodule

// File: tb/tb_am2940_sequencer.sv
// Randomised and directed bench for am2940_sequencer; a transaction-level
// model (setup-word queue plus run phase) predicts every output each cycle.
module tb_am2940_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, xfer_ack, done_in;
  logic [2:0] cr_cfg;
  logic [7:0] addr_cfg, wc_cfg;
  logic       xfer_req, d_oe, busy, done_irq, abort_irq;
  logic [2:0] i_out;
  logic [7:0] d_out, xfer_cnt;

  am2940_sequencer #(.DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cr_cfg(cr_cfg), .addr_cfg(addr_cfg), .wc_cfg(wc_cfg),
    .xfer_req(xfer_req), .xfer_ack(xfer_ack), .done_in(done_in),
    .i_out(i_out), .d_out(d_out), .d_oe(d_oe), .busy(busy),
    .xfer_cnt(xfer_cnt), .done_irq(done_irq), .abort_irq(abort_irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Stimulus policy knobs.
  int unsigned ack_prob = 100, abort_prob = 0, start_prob = 0;
  bit          done_mode = 1'b1, cfg_churn = 1'b0;
  int          done_after = 1000;

  // Observation counters fed by the compare process.
  int         steps_seen = 0, done_seen = 0, abort_seen = 0, ldwc_seen = 0;
  logic [10:0] obs_q[$];

  // Model: phases of one transfer, plus the queue of setup words still to be written.
  localparam int P_IDLE = 0, P_SETUP = 1, P_WAIT = 2, P_STEP = 3, P_CHK = 4;
  int          m_phase = P_IDLE;
  logic [10:0] setup_q[$];
  logic [10:0] m_word = 11'h000;
  logic [7:0]  m_cnt = 8'h00;
  bit          m_done = 1'b0, m_abort = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_phase = P_IDLE; setup_q.delete(); m_word = 11'h000;
      m_cnt = 8'h00; m_done = 1'b0; m_abort = 1'b0;
    end else begin
      m_done = 1'b0; m_abort = 1'b0;
      if (m_phase != P_IDLE && abort) begin
        m_phase = P_IDLE; m_abort = 1'b1; setup_q.delete();
      end else begin
        case (m_phase)
          P_IDLE: if (start) begin
            m_cnt = 8'h00;
            setup_q.push_back({3'b000, 5'b00000, cr_cfg});
            setup_q.push_back({3'b101, addr_cfg});
            if (cr_cfg[1:0] != 2'b01) setup_q.push_back({3'b110, wc_cfg});
            m_word  = setup_q.pop_front();
            m_phase = P_SETUP;
          end
          P_SETUP: if (setup_q.size() > 0) m_word = setup_q.pop_front();
                   else m_phase = P_WAIT;
          P_WAIT:  if (xfer_ack) begin m_phase = P_STEP; m_cnt = m_cnt + 8'd1; end
          P_STEP:  m_phase = P_CHK;
          P_CHK:   if (done_in) begin m_phase = P_IDLE; m_done = 1'b1; end
                   else m_phase = P_WAIT;
          default: m_phase = P_IDLE;
        endcase
      end
    end
  endtask

  // Inputs only change at negedge+1, so at negedge they still hold what the last posedge sampled.
  always @(negedge clk) begin
    logic [2:0] e_i;
    logic [7:0] e_d;
    model_step();
    e_i = 3'b001; e_d = 8'h00;
    if (m_phase == P_SETUP) begin e_i = m_word[10:8]; e_d = m_word[7:0]; end
    if (m_phase == P_STEP) e_i = 3'b111;
    chk("i_out", {29'd0, i_out}, {29'd0, e_i});
    chk("d_out", {24'd0, d_out}, {24'd0, e_d});
    chk("d_oe", {31'd0, d_oe}, {31'd0, m_phase == P_SETUP});
    chk("xfer_req", {31'd0, xfer_req}, {31'd0, m_phase == P_WAIT});
    chk("busy", {31'd0, busy}, {31'd0, m_phase != P_IDLE});
    chk("xfer_cnt", {24'd0, xfer_cnt}, {24'd0, m_cnt});
    chk("done_irq", {31'd0, done_irq}, {31'd0, m_done});
    chk("abort_irq", {31'd0, abort_irq}, {31'd0, m_abort});
    if (i_out == 3'b111) steps_seen++;
    if (i_out == 3'b110) ldwc_seen++;
    if (done_irq) done_seen++;
    if (abort_irq) abort_seen++;
    if (d_oe) obs_q.push_back({i_out, d_out});
  end

  task automatic cyc();
    @(negedge clk); #1;
    xfer_ack = ($urandom_range(99) < ack_prob);
    done_in  = done_mode ? (steps_seen >= done_after) : ($urandom_range(99) < 30);
    abort    = ($urandom_range(99) < abort_prob);
    start    = ($urandom_range(99) < start_prob);
    if (cfg_churn) begin
      cr_cfg = 3'($urandom); addr_cfg = 8'($urandom); wc_cfg = 8'($urandom);
    end
  endtask

  task automatic do_start(input logic [2:0] cr, input logic [7:0] addr,
                          input logic [7:0] wc, output int lat);
    @(negedge clk); #1;
    steps_seen = 0; done_seen = 0; abort_seen = 0; ldwc_seen = 0; obs_q.delete();
    start = 1'b1; abort = 1'b0; xfer_ack = 1'b0; done_in = 1'b0;
    cr_cfg = cr; addr_cfg = addr; wc_cfg = wc;
    @(negedge clk); #1;
    start = 1'b0;
    cr_cfg = 3'($urandom); addr_cfg = 8'($urandom); wc_cfg = 8'($urandom);
    lat = 1;
    while (!xfer_req && lat < 20) begin cyc(); lat++; end
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin cyc(); n++; end
    start = 1'b0; abort = 1'b0;
    chk("idle_within_budget", {31'd0, busy}, 32'd0);
    @(negedge clk); #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_i_out"}, {29'd0, i_out}, 32'd1);
    chk({tag, "_d_out"}, {24'd0, d_out}, 32'd0);
    chk({tag, "_d_oe"}, {31'd0, d_oe}, 32'd0);
    chk({tag, "_xfer_req"}, {31'd0, xfer_req}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_xfer_cnt"}, {24'd0, xfer_cnt}, 32'd0);
    chk({tag, "_done_irq"}, {31'd0, done_irq}, 32'd0);
    chk({tag, "_abort_irq"}, {31'd0, abort_irq}, 32'd0);
  endtask

  initial begin
    int lat, n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; xfer_ack = 1'b0; done_in = 1'b0;
    cr_cfg = 3'b000; addr_cfg = 8'h00; wc_cfg = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_values("reset");
    rst_n = 1'b1;
    cyc();

    // Basic three-word transfer with cfg churning after capture.
    cfg_churn = 1'b1; done_mode = 1'b1; done_after = 3;
    do_start(3'b000, 8'h10, 8'h03, lat);
    chk("latency_full", lat, 4);
    run_until_idle(100);
    chk("basic_cnt", {24'd0, xfer_cnt}, 32'd3);
    chk("basic_steps", steps_seen, 3);
    chk("basic_done", done_seen, 1);
    chk("basic_abort", abort_seen, 0);
    chk("basic_words", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      chk("basic_wr_cr", {21'd0, obs_q[0]}, {21'd0, 3'b000, 8'h00});
      chk("basic_ld_addr", {21'd0, obs_q[1]}, {21'd0, 3'b101, 8'h10});
      chk("basic_ld_wc", {21'd0, obs_q[2]}, {21'd0, 3'b110, 8'h03});
    end

    // Address-compare mode skips the word-count load.
    done_after = 2;
    do_start(3'b001, 8'h20, 8'h05, lat);
    chk("latency_skip", lat, 3);
    run_until_idle(100);
    chk("skip_ldwc", ldwc_seen, 0);
    chk("skip_words", obs_q.size(), 2);
    if (obs_q.size() == 2) chk("skip_ld_addr", {21'd0, obs_q[1]}, {21'd0, 3'b101, 8'h20});

    // Start pulses while busy must not restart the sequence.
    done_after = 4; start_prob = 50;
    do_start(3'b010, 8'h33, 8'h04, lat);
    run_until_idle(100);
    start_prob = 0;
    chk("busy_start_words", obs_q.size(), 3);
    chk("busy_start_cnt", {24'd0, xfer_cnt}, 32'd4);
    chk("busy_start_done", done_seen, 1);

    // Abort coincident with the second acknowledge.
    done_after = 1000;
    do_start(3'b000, 8'h44, 8'h08, lat);
    n = 0;
    while (!(xfer_req && steps_seen == 1) && n < 50) begin cyc(); n++; end
    chk("abort_window_reached", {31'd0, xfer_req}, 32'd1);
    abort = 1'b1; xfer_ack = 1'b1;
    cyc();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_irq_pulse", {31'd0, abort_irq}, 32'd1);
    chk("abort_no_done", {31'd0, done_irq}, 32'd0);
    chk("abort_cnt_held", {24'd0, xfer_cnt}, 32'd1);
    cyc();
    chk("abort_no_extra_step", steps_seen, 1);

    // Abort in IDLE is ignored.
    abort_prob = 100; abort_seen = 0;
    repeat (3) cyc();
    abort_prob = 0;
    cyc();
    chk("idle_abort_ignored", abort_seen, 0);

    // Word count 0 means 256 words; the counter wraps.
    done_after = 256;
    do_start(3'b000, 8'h00, 8'h00, lat);
    run_until_idle(1200);
    chk("wrap_steps", steps_seen, 256);
    chk("wrap_cnt", {24'd0, xfer_cnt}, 32'd0);
    chk("wrap_done", done_seen, 1);

    // Asynchronous reset during RUN.
    done_after = 1000; ack_prob = 0;
    do_start(3'b000, 8'h40, 8'h10, lat);
    repeat (2) cyc();
    rst_n = 1'b0;
    #1;
    chk_reset_values("async_reset");
    @(negedge clk); #1;
    rst_n = 1'b1; done_seen = 0; abort_seen = 0;
    repeat (3) cyc();
    chk("post_reset_no_irq", done_seen + abort_seen, 0);
    chk("post_reset_idle", {31'd0, busy}, 32'd0);

    // Random stress: everything at once.
    done_mode = 1'b0; abort_prob = 3; start_prob = 20;
    for (int k = 0; k < 3000; k++) begin
      if (k % 200 == 0) ack_prob = $urandom_range(100);
      cyc();
    end
    abort_prob = 0; start_prob = 0; ack_prob = 100; done_mode = 1'b1; done_after = 0;
    run_until_idle(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
    $finish;
  end

endmodule
